// File: rtl/cpu_pkg.sv
// Shared definitions for the program-counter datapath: reset/step defaults,
// PC update FSM encoding and the branch offset scaling helper.
package cpu_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEFAULT  = 4;

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StHoldSeq = 2'b01,
    StHoldBr  = 2'b10
  } pc_state_e;

  // Branch offsets are signed word counts; convert to a 32-bit byte displacement.
  function automatic logic [31:0] word_offset(input logic [7:0] offset);
    return {{22{offset[7]}}, offset, 2'b00};
  endfunction

endpackage

// File: rtl/branch_adder.sv
// Branch target adder: sequential PC plus the sign-extended, word-scaled offset.
module branch_adder
  import cpu_pkg::*;
(
  input  logic [31:0] seq_i,
  input  logic [7:0]  offset_i,
  output logic [31:0] target_o
);

  assign target_o = seq_i + word_offset(offset_i);

endmodule

// File: rtl/pc_unit.sv
// Program counter with jump/branch redirect and a stall FSM that holds the PC
// (and any pending redirect) while instruction or data memory is busy.
module pc_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        J,
  input  logic        BEQ,
  input  logic        BNEQ,
  input  logic        ZERO,
  input  logic [7:0]  OFFSET,
  input  logic        I_BUSYWAIT,
  input  logic        D_BUSYWAIT,
  output logic [31:0] PC,
  output logic        TAKEN,
  output logic [31:0] INSTR_COUNT
);

  pc_state_e   state_q;
  logic [31:0] pc_q;
  logic [31:0] target_q;
  logic [31:0] count_q;
  logic        taken_q;

  logic        take;
  logic        stall;
  logic [31:0] seq;
  logic [31:0] target;

  assign take  = J | (BEQ & ZERO) | (BNEQ & ~ZERO);
  assign stall = I_BUSYWAIT | D_BUSYWAIT;
  assign seq   = pc_q + 32'(PC_STEP);

  branch_adder u_branch_adder (
    .seq_i    (seq),
    .offset_i (OFFSET),
    .target_o (target)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= StRun;
      pc_q     <= PC_RESET;
      target_q <= 32'h0;
      count_q  <= 32'h0;
      taken_q  <= 1'b0;
    end else begin
      taken_q <= 1'b0;
      case (state_q)
        StRun: begin
          if (stall) begin
            // Remember the redirect decision now; control inputs may move during the stall.
            state_q <= take ? StHoldBr : StHoldSeq;
            if (take) begin
              target_q <= target;
            end
          end else begin
            pc_q    <= take ? target : seq;
            taken_q <= take;
            count_q <= count_q + 32'd1;
          end
        end
        StHoldSeq: begin
          if (!stall) begin
            pc_q    <= seq;
            count_q <= count_q + 32'd1;
            state_q <= StRun;
          end
        end
        StHoldBr: begin
          if (!stall) begin
            pc_q    <= target_q;
            taken_q <= 1'b1;
            count_q <= count_q + 32'd1;
            state_q <= StRun;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign PC          = pc_q;
  assign TAKEN       = taken_q;
  assign INSTR_COUNT = count_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a behavioural model queues the expected PC,
// TAKEN and INSTR_COUNT for each driven cycle; they are popped after the edge.
module tb_pc_unit;

  logic        CLK;
  logic        RESET;
  logic        J, BEQ, BNEQ, ZERO;
  logic [7:0]  OFFSET;
  logic        I_BUSYWAIT, D_BUSYWAIT;
  logic [31:0] PC;
  logic        TAKEN;
  logic [31:0] INSTR_COUNT;

  pc_unit dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .J           (J),
    .BEQ         (BEQ),
    .BNEQ        (BNEQ),
    .ZERO        (ZERO),
    .OFFSET      (OFFSET),
    .I_BUSYWAIT  (I_BUSYWAIT),
    .D_BUSYWAIT  (D_BUSYWAIT),
    .PC          (PC),
    .TAKEN       (TAKEN),
    .INSTR_COUNT (INSTR_COUNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: mode 0 = running, 1 = holding sequential, 2 = holding redirect.
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic [31:0] m_tgt;
  int          m_mode;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc   = 32'h0;
    m_cnt  = 32'h0;
    m_tgt  = 32'h0;
    m_mode = 0;
  endtask

  task automatic cycle(input string tag, input logic j, input logic beq, input logic bneq,
                       input logic zero, input logic [7:0] off, input logic ib,
                       input logic db);
    logic        take, stall, m_taken;
    logic [31:0] seq, tgt, disp;
    exp_t        e, got;
    J = j; BEQ = beq; BNEQ = bneq; ZERO = zero; OFFSET = off;
    I_BUSYWAIT = ib; D_BUSYWAIT = db;

    take  = j | (beq & zero) | (bneq & ~zero);
    stall = ib | db;
    seq   = m_pc + 32'd4;
    disp  = {{24{off[7]}}, off};
    tgt   = seq + disp * 32'd4;
    m_taken = 1'b0;
    case (m_mode)
      0: begin
        if (stall) begin
          m_mode = take ? 2 : 1;
          if (take) m_tgt = tgt;
        end else begin
          m_pc    = take ? tgt : seq;
          m_taken = take;
          m_cnt   = m_cnt + 32'd1;
        end
      end
      1: if (!stall) begin
        m_pc = seq; m_cnt = m_cnt + 32'd1; m_mode = 0;
      end
      default: if (!stall) begin
        m_pc = m_tgt; m_taken = 1'b1; m_cnt = m_cnt + 32'd1; m_mode = 0;
      end
    endcase
    e.tag = tag; e.pc = m_pc; e.taken = m_taken; e.cnt = m_cnt;
    sb.push_back(e);

    @(posedge CLK);
    #1;
    got = sb.pop_front();
    check_eq({got.tag, ".pc"}, PC, got.pc);
    check_eq({got.tag, ".taken"}, {31'h0, TAKEN}, {31'h0, got.taken});
    check_eq({got.tag, ".count"}, INSTR_COUNT, got.cnt);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    RESET = 1'b0;
    J = 0; BEQ = 0; BNEQ = 0; ZERO = 0; OFFSET = 8'h00;
    I_BUSYWAIT = 0; D_BUSYWAIT = 0;
    model_reset();
    #12;
    check_eq("reset.pc", PC, 32'h0);
    check_eq("reset.taken", {31'h0, TAKEN}, 32'h0);
    check_eq("reset.count", INSTR_COUNT, 32'h0);
    RESET = 1'b1;

    // Sequential run 0 -> 4 -> 8 -> 12
    for (int i = 0; i < 3; i++) idle($sformatf("seq%0d", i));

    // Backward jumps: 12 -> 8, then 8 -> 4, then pulse ends
    cycle("j_12", 1'b1, 0, 0, 0, 8'hFE, 0, 0);
    cycle("j_8",  1'b1, 0, 0, 0, 8'hFE, 0, 0);
    idle("after_j");
    // BEQ not taken at PC=8
    cycle("beq_nt", 0, 1'b1, 0, 0, 8'hFE, 0, 0);
    idle("to16");

    // BNEQ taken at 16 with instruction-memory stall for 3 edges
    for (int i = 0; i < 3; i++) cycle($sformatf("bneq_stall%0d", i), 0, 0, 1'b1, 0, 8'h03, 1'b1, 0);
    idle("bneq_release");

    // Zero offset and self-loop, then both branch requests high
    cycle("off0",  1'b1, 0, 0, 0, 8'h00, 0, 0);
    cycle("offff", 1'b1, 0, 0, 0, 8'hFF, 0, 0);
    cycle("beq_bneq", 0, 1'b1, 1'b1, 1'b1, 8'h01, 0, 0);
    // 44 -> 16
    cycle("back16", 1'b1, 0, 0, 0, 8'hF8, 0, 0);

    // Redirect latched at 16 under data stall; inputs move during hold
    cycle("hb_enter", 1'b1, 0, 0, 0, 8'h05, 0, 1'b1);
    cycle("hb_hold0", 1'b1, 1'b1, 0, 1'b1, 8'h80, 0, 1'b1);
    cycle("hb_hold1", 0, 0, 1'b1, 0, 8'h7F, 1'b1, 1'b1);
    idle("hb_release");

    // Sequential hold: jump request on the release edge is ignored
    cycle("hs_enter", 0, 0, 0, 0, 8'h00, 1'b1, 0);
    cycle("hs_release", 1'b1, 0, 0, 0, 8'h10, 0, 0);

    // Wrap: 44 -> 0xFFFFFFFC -> 0
    cycle("to_top", 1'b1, 0, 0, 0, 8'hF3, 0, 0);
    idle("wrap");

    // Async reset while holding a redirect discards it
    cycle("rst_hb_enter", 1'b1, 0, 0, 0, 8'h05, 0, 1'b1);
    cycle("rst_hb_hold", 0, 0, 0, 0, 8'h00, 0, 1'b1);
    #3;
    RESET = 1'b0;
    #1;
    model_reset();
    check_eq("async_rst.pc", PC, 32'h0);
    check_eq("async_rst.taken", {31'h0, TAKEN}, 32'h0);
    check_eq("async_rst.count", INSTR_COUNT, 32'h0);
    D_BUSYWAIT = 1'b0;
    #2;
    RESET = 1'b1;
    idle("post_rst0");
    idle("post_rst1");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
